rv32i_fetch_unit: RTL and testbench
===================================

Name: rv32i_fetch_unit

Overview:
Instruction fetch stage that sits directly downstream of the instruction memory, which the test flow loads from IMEM.txt.
- Holds the PC and issues word reads to the synchronous-read IMEM.
- Buffers returned words and presents {instruction, PC} to the decoder over a valid/ready handshake.
- Accepts redirects from execute and discards any fetches from the stale stream.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
IMEM_ADDR_W, 10, IMEM word-address width (1024 words)

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous active-high reset
o_imem_rd_en  out  1  IMEM read strobe
o_imem_addr  out  IMEM_ADDR_W  word address = PC[IMEM_ADDR_W+1:2]
i_imem_rdata  in  32  read data; valid the cycle after o_imem_rd_en
i_redirect  in  1  single-cycle request to change the PC
i_redirect_pc  in  32  redirect target byte address
o_inst_valid  out  1  o_inst / o_inst_pc valid
i_inst_ready  in  1  decoder accepts this cycle
o_inst  out  32  instruction word
o_inst_pc  out  32  byte address of o_inst
o_misaligned  out  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
Reset
- While i_rst is high:
  - PC = RESET_PC.
  - Buffer empty; in-flight flag cleared.
  - o_imem_rd_en = 0, o_inst_valid = 0, o_misaligned = 0, o_inst = 0, o_inst_pc = 0.
- Reset mid-operation drops all buffered and in-flight words.

Storage
- 2-entry FIFO (output register plus skid entry); each entry holds {inst, pc}.
- 1-bit in-flight flag, plus the PC of the in-flight read.

Read issue
- Rule: o_imem_rd_en = !i_rst && !i_redirect && (count + inflight - pop) < 2, where pop = o_inst_valid && i_inst_ready.
- On issue: in-flight flag set; PC <= PC + 4.
- PC is 32-bit and wraps from 0xFFFF_FFFC to 0x0. o_imem_addr wraps modulo IMEM depth.
- Response: the cycle after an issue, i_imem_rdata and the in-flight PC are pushed into the FIFO tail.
- Throughput: 1 instruction/cycle with i_inst_ready held high.
- Latency:
  - First o_inst_valid 2 cycles after i_rst deasserts: read issued cycle 1, valid cycle 2.
  - After a redirect cycle: read at cycle+1, valid at cycle+2.

Handshake
- o_inst_valid = FIFO non-empty; o_inst / o_inst_pc are the FIFO head.
- While valid && !ready, o_inst and o_inst_pc are held stable.
- Push and pop in the same cycle are both honoured.
- Never loses, duplicates or reorders instructions. Occupancy + in-flight never exceeds 2.

Redirect (i_redirect = 1)
- PC <= {i_redirect_pc[31:2], 2'b00}.
- o_misaligned pulses on the next cycle iff i_redirect_pc[1:0] != 0.
- If o_inst_valid && i_inst_ready is true in the same cycle, that handshake completes first; all remaining FIFO entries are then flushed.
- The in-flight response returning next cycle is discarded (kill flag).
- No read is issued in the redirect cycle.
- o_inst_valid = 0 on the cycle after the redirect.
- Back-to-back redirects: the last one wins. Each redirect restarts the 2-cycle latency.

Boundary conditions
- FIFO full with i_inst_ready = 0: no reads issued; PC frozen.
- Empty with a response arriving and i_inst_ready = 1: the word appears on o_inst the cycle after the response, no bypass path.
- i_imem_rdata is ignored when no unkilled read is outstanding.

Test Plan:
1. IMEM[0] = 0x00500093 (ADDI x1,x0,5), IMEM[1] = 0x002081B3 (ADD x3,x1,x2), ready high, release reset -> cycle 2: o_inst = 0x00500093, pc 0x0; cycle 3: o_inst = 0x002081B3, pc 0x4; valid every cycle thereafter.
2. Sequential stream, drop i_inst_ready for 3 cycles mid-stream -> o_inst/o_inst_pc held; o_imem_rd_en low once 2 words are held or in flight; after ready rises, PCs continue +4 with no gaps or duplicates.
3. Redirect to 0x40 while one word is buffered and one in flight; IMEM[16] = 0x00A00113 -> o_inst_valid = 0 next cycle; next valid word is 0x00A00113 at pc 0x40; no pc 0x8/0xC emitted.
4. Redirect to 0x42 -> o_misaligned high for exactly one cycle; fetch resumes at pc 0x40.
5. Redirect in the same cycle as a handshake at pc 0x4 -> pc 0x4 is consumed exactly once; pc 0x8 is never emitted.
6. RESET_PC = 0xFFFF_FFF8 -> emitted pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0 with o_imem_addr wrapping; then assert i_rst mid-stream -> o_inst_valid = 0 the next cycle, restart at RESET_PC.

Source files
------------

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: issues IMEM word reads, buffers responses in a
// 2-entry skid FIFO and hands {inst, pc} to decode, honouring execute redirects.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic                   o_imem_rd_en,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  input  logic [31:0]            i_imem_rdata,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirect_pc,
  output logic                   o_inst_valid,
  input  logic                   i_inst_ready,
  output logic [31:0]            o_inst,
  output logic [31:0]            o_inst_pc,
  output logic                   o_misaligned
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] ent0_inst_q, ent0_inst_d, ent0_pc_q, ent0_pc_d;
  logic [31:0] ent1_inst_q, ent1_inst_d, ent1_pc_q, ent1_pc_d;
  logic        misaligned_q, misaligned_d;

  logic        pop_s;
  logic        push_s;
  logic        rd_en_s;
  logic [2:0]  occ_s;

  // Next-state logic: read issue, PC update and FIFO push/pop/flush.
  always_comb begin
    pop_s   = (cnt_q != 2'd0) && i_inst_ready;
    // A response arriving in a redirect cycle belongs to the stale stream.
    push_s  = inflight_q && !i_redirect;
    occ_s   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s = !i_rst && !i_redirect && (occ_s < 3'd2);

    cnt_d         = cnt_q;
    ent0_inst_d   = ent0_inst_q;
    ent0_pc_d     = ent0_pc_q;
    ent1_inst_d   = ent1_inst_q;
    ent1_pc_d     = ent1_pc_q;
    inflight_d    = rd_en_s;
    misaligned_d  = i_redirect && (i_redirect_pc[1:0] != 2'b00);

    if (rd_en_s) begin
      inflight_pc_d = pc_q;
    end else begin
      inflight_pc_d = inflight_pc_q;
    end

    if (i_redirect) begin
      pc_d = {i_redirect_pc[31:2], 2'b00};
    end else if (rd_en_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    if (i_redirect) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            ent0_inst_d = i_imem_rdata;
            ent0_pc_d   = inflight_pc_q;
          end else begin
            ent0_inst_d = ent1_inst_q;
            ent0_pc_d   = ent1_pc_q;
            ent1_inst_d = i_imem_rdata;
            ent1_pc_d   = inflight_pc_q;
          end
        end
        2'b10: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            ent0_inst_d = i_imem_rdata;
            ent0_pc_d   = inflight_pc_q;
          end else begin
            ent1_inst_d = i_imem_rdata;
            ent1_pc_d   = inflight_pc_q;
          end
        end
        2'b01: begin
          cnt_d       = cnt_q - 2'd1;
          ent0_inst_d = ent1_inst_q;
          ent0_pc_d   = ent1_pc_q;
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      cnt_q         <= 2'd0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0000_0000;
      ent0_inst_q   <= 32'h0000_0000;
      ent0_pc_q     <= 32'h0000_0000;
      ent1_inst_q   <= 32'h0000_0000;
      ent1_pc_q     <= 32'h0000_0000;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      cnt_q         <= cnt_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      ent0_inst_q   <= ent0_inst_d;
      ent0_pc_q     <= ent0_pc_d;
      ent1_inst_q   <= ent1_inst_d;
      ent1_pc_q     <= ent1_pc_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign o_imem_rd_en = rd_en_s;
  assign o_imem_addr  = pc_q[IMEM_ADDR_W+1:2];
  assign o_inst_valid = (cnt_q != 2'd0);
  assign o_inst       = ent0_inst_q;
  assign o_inst_pc    = ent0_pc_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Bench for rv32i_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rv32i_fetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic        clk;
  logic        i_rst, i_redirect, i_inst_ready;
  logic [31:0] i_redirect_pc;
  logic        o_imem_rd_en;
  logic [9:0]  o_imem_addr;
  logic [31:0] imem_rdata;
  logic        o_inst_valid, o_misaligned;
  logic [31:0] o_inst, o_inst_pc;

  logic        rst2, rd2_en, valid2, mis2, redirect2, ready2;
  logic [9:0]  addr2;
  logic [31:0] rdata2, inst2, pc2, rpc2;

  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  ent_t        m_fifo[$];
  logic        m_pend;
  logic [31:0] m_pend_pc;
  logic [31:0] m_pc;
  logic        m_mis;

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_ADDR_W(10)) u_dut (
    .i_clk(clk), .i_rst(i_rst),
    .o_imem_rd_en(o_imem_rd_en), .o_imem_addr(o_imem_addr), .i_imem_rdata(imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_misaligned(o_misaligned)
  );

  rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_ADDR_W(10)) u_dut_hi (
    .i_clk(clk), .i_rst(rst2),
    .o_imem_rd_en(rd2_en), .o_imem_addr(addr2), .i_imem_rdata(rdata2),
    .i_redirect(redirect2), .i_redirect_pc(rpc2),
    .o_inst_valid(valid2), .i_inst_ready(ready2),
    .o_inst(inst2), .o_inst_pc(pc2), .o_misaligned(mis2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read IMEM models; garbage is returned when no read was issued.
  always @(posedge clk) begin
    if (o_imem_rd_en) imem_rdata <= mem[o_imem_addr];
    else              imem_rdata <= $urandom;
    if (rd2_en) rdata2 <= mem[addr2];
    else        rdata2 <= $urandom;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check read strobe, advance model, check outputs.
  task automatic step(input logic rst, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic pop;
    logic exp_rd;
    int   occ;
    ent_t e;
    @(negedge clk);
    i_rst = rst; i_redirect = rd; i_redirect_pc = rpc; i_inst_ready = rdy;
    #1;
    pop = 1'b0;
    if (rst) begin
      exp_rd = 1'b0;
    end else begin
      pop    = (m_fifo.size() > 0) && rdy;
      occ    = m_fifo.size() + (m_pend ? 1 : 0) - (pop ? 1 : 0);
      exp_rd = !rd && (occ < 2);
    end
    chk("imem_rd_en", {31'd0, o_imem_rd_en}, {31'd0, exp_rd});
    if (exp_rd) chk("imem_addr", {22'd0, o_imem_addr}, {22'd0, m_pc[11:2]});

    if (rst) begin
      m_fifo.delete(); m_pend = 1'b0; m_pc = 32'h0000_0000; m_mis = 1'b0;
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rd) begin
        m_fifo.delete();
        m_pend = 1'b0;
        m_pc   = {rpc[31:2], 2'b00};
        m_mis  = (rpc[1:0] != 2'b00);
      end else begin
        if (m_pend) begin
          e.inst = mem[m_pend_pc[11:2]];
          e.pc   = m_pend_pc;
          m_fifo.push_back(e);
        end
        m_mis = 1'b0;
        if (exp_rd) begin
          m_pend = 1'b1; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
        end else begin
          m_pend = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    chk("inst_valid", {31'd0, o_inst_valid}, {31'd0, (m_fifo.size() > 0)});
    chk("misaligned", {31'd0, o_misaligned}, {31'd0, m_mis});
    if (m_fifo.size() > 0) begin
      chk("inst", o_inst, m_fifo[0].inst);
      chk("inst_pc", o_inst_pc, m_fifo[0].pc);
    end
  endtask

  initial begin
    logic [31:0] hold_inst, hold_pc;
    logic        found;
    logic        r_rst, r_rd, r_rdy;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h0020_81B3;
    mem[16] = 32'h00A0_0113;
    i_rst = 1'b1; i_redirect = 1'b0; i_redirect_pc = 32'h0; i_inst_ready = 1'b1;
    rst2 = 1'b1; redirect2 = 1'b0; rpc2 = 32'h0; ready2 = 1'b1;
    m_fifo.delete(); m_pend = 1'b0; m_pend_pc = 32'h0; m_pc = 32'h0; m_mis = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("rst_valid", {31'd0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'h0);
    chk("rst_pc", o_inst_pc, 32'h0);
    chk("rst_mis", {31'd0, o_misaligned}, 32'd0);

    // Test 1: first two instructions after reset release
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_c1_valid", {31'd0, o_inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_c2_inst", o_inst, 32'h0050_0093);
    chk("t1_c2_pc", o_inst_pc, 32'h0000_0000);
    chk("t1_model_pin", m_fifo[0].inst, 32'h0050_0093);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t1_c3_inst", o_inst, 32'h0020_81B3);
    chk("t1_c3_pc", o_inst_pc, 32'h0000_0004);

    // Test 2: decoder stall mid-stream
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    hold_inst = o_inst; hold_pc = o_inst_pc;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk("t2_hold_inst", o_inst, hold_inst);
      chk("t2_hold_pc", o_inst_pc, hold_pc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Test 3: redirect with one word buffered and one in flight
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0);
    chk("t3_valid_after", {31'd0, o_inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_valid_gap", {31'd0, o_inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t3_inst", o_inst, 32'h00A0_0113);
    chk("t3_pc", o_inst_pc, 32'h0000_0040);

    // Test 4: misaligned redirect target
    step(1'b0, 1'b1, 32'h0000_0042, 1'b1);
    chk("t4_mis_pulse", {31'd0, o_misaligned}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_mis_clear", {31'd0, o_misaligned}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t4_resume_pc", o_inst_pc, 32'h0000_0040);

    // Test 5: redirect coinciding with the handshake of pc 0x4
    step(1'b0, 1'b1, 32'h0000_0000, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (o_inst_valid && o_inst_pc == 32'h4) found = 1'b1;
      else step(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("t5_reach_pc4", {31'd0, found}, 32'd1);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    chk("t5_valid_after", {31'd0, o_inst_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_next_pc", o_inst_pc, 32'h0000_0100);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_rd  = ($urandom_range(0, 19) == 0);
      r_rdy = ($urandom_range(0, 9) < 7);
      step(r_rst, r_rd, $urandom, r_rdy);
    end

    // Test 6: RESET_PC near the top of the address space, wrap and mid-stream reset
    @(negedge clk); rst2 = 1'b0; #1;
    chk("t6_rd_en", {31'd0, rd2_en}, 32'd1);
    chk("t6_addr0", {22'd0, addr2}, 32'd1022);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("t6_addr1", {22'd0, addr2}, 32'd1023);
    @(posedge clk); #1;
    chk("t6_valid", {31'd0, valid2}, 32'd1);
    chk("t6_pc0", pc2, 32'hFFFF_FFF8);
    chk("t6_inst0", inst2, mem[1022]);
    @(negedge clk); #1;
    chk("t6_addr_wrap", {22'd0, addr2}, 32'd0);
    @(posedge clk); #1;
    chk("t6_pc1", pc2, 32'hFFFF_FFFC);
    chk("t6_inst1", inst2, mem[1023]);
    @(posedge clk); #1;
    chk("t6_pc_wrap", pc2, 32'h0000_0000);
    chk("t6_inst_wrap", inst2, 32'h0050_0093);
    @(negedge clk); rst2 = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_valid", {31'd0, valid2}, 32'd0);
    chk("t6_rst_pc", pc2, 32'h0);
    @(negedge clk); rst2 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("t6_restart_valid", {31'd0, valid2}, 32'd1);
    chk("t6_restart_pc", pc2, 32'hFFFF_FFF8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
